mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch (IF) port and the data-memory (MEM-stage) port of the 5-stage pipeline. Arbitrates and sequences variable-latency memory transactions, buffers each port's completed result until the pipeline advances, and produces the pipeline-wide memory stall. It sits beside the hazard/stall control: its `pipe_stall` is ORed into the hazard stall. An IF flush from branch/JAL/JALR redirect cancels the in-flight fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, max cycles `mem_req` may wait for `mem_ack` before forced completion
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch wanted this cycle
- `if_addr`  in  ADDR_W  fetch address (PC)
- `if_flush`  in  1  one-cycle pulse: PC redirected, discard current fetch
- `if_rdata`  out  DATA_W  fetched instruction, valid while `if_done`
- `if_done`  out  1  fetch result buffered
- `dm_req`  in  1  load/store wanted this cycle
- `dm_we`  in  1  1 = store
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_rdata`  out  DATA_W  load data, valid while `dm_done`
- `dm_done`  out  1  data access complete
- `pipe_stall`  out  1  `(if_req & ~if_done) | (dm_req & ~dm_done)`, combinational
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`  out  1/1/ADDR_W/DATA_W  memory command
- `mem_ack`  in  1  one-cycle completion pulse
- `mem_rdata`  in  DATA_W  valid in the `mem_ack` cycle
- `mem_err`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, FETCH, DATA.
- IDLE: if `dm_req & ~dm_done` → DATA; else if `if_req & ~if_done & ~if_flush` → FETCH. Data wins over fetch (older instruction).
- On grant, `mem_addr/mem_we/mem_wdata` are registered from the granted port and held stable. `mem_we` = 0 in FETCH.
- `mem_req` = 1 exactly while state ∈ {FETCH, DATA}.
- `mem_ack` in FETCH: `if_rdata` ← `mem_rdata` and `if_done` ← 1, unless the fetch is stale. Then → IDLE.
- `mem_ack` in DATA: `dm_rdata` ← `mem_rdata` (stores leave it unchanged) and `dm_done` ← 1. Then → IDLE.
- Done flags clear on any edge where `pipe_stall` = 0 (pipeline advances). A port with its done flag set is never re-granted.
- `if_flush`:
  - clears `if_done`;
  - if in FETCH, sets a stale bit. The transaction still runs to `mem_ack` (memory cannot abort), its data is dropped, then the fetch is re-arbitrated with the new `if_addr`.
  - If `if_flush` and `mem_ack` fall in the same FETCH cycle, the data is dropped.
- Timeout: a wait counter counts cycles in FETCH/DATA and clears on grant.
  - At `TIMEOUT` without `mem_ack`: complete as if acked with rdata = 0, set `mem_err`, go to IDLE.
  - `mem_err` clears only on reset.
- `mem_ack` outside FETCH/DATA is ignored.

## Timing
- Reset values: state IDLE; all outputs 0 (`pipe_stall` follows its inputs); stale bit 0; counter 0.
- Reset mid-transaction: immediately IDLE, `mem_req` drops. The memory must tolerate the dropped request.
- Zero-wait memory (ack in first `mem_req` cycle):
  - request seen cycle 0, `mem_req` cycle 1, `*_done` cycle 2.
  - Load+fetch both pending: `dm_done` cycle 2, `if_done` cycle 4, `pipe_stall` low in cycle 4.
- Requesters hold `*_req`/address/data stable while stalled.

## Structure
- Shared package `mem_pkg`: FSM state enum (IDLE/FETCH/DATA), default `ADDR_W`/`DATA_W`.
- One natural sub-module: `mem_port_buf`, per-port done flag + data register with set/clear/flush, instantiated twice.
- FSM, timeout counter and command registers stay in the top.

## Test plan
- Fetch only, ack latency 0, `if_addr`=0x40, rdata 0x00500093 → `mem_req` cycle 1 with addr 0x40; `if_done`=1 cycle 2 with that data; `pipe_stall` low cycle 2.
- Load 0x100 and fetch 0x44 together, latency 2 → data granted first; fetch `mem_req` only after `dm_done`; `pipe_stall` stays high until both done, then both done flags clear.
- Store 0x200←0xDEADBEEF → `mem_we`=1 with stable addr/wdata until ack; `dm_rdata` unchanged.
- `if_flush` during a 3-cycle fetch to 0x80, new PC 0xC0 → first result discarded; `if_done` only after a second transaction to 0xC0.
- Flush coincident with `mem_ack` → data dropped, refetch issued.
- No ack for `TIMEOUT`=4 cycles → forced completion with rdata 0, `mem_err`=1 sticky until `rst_n` low; reset asserted mid-FETCH → `mem_req` 0 immediately.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory port arbiter.
//   - arb_state_e : arbiter FSM states (IDLE / FETCH / DATA)
//   - MEM_ADDR_W  : default address width
//   - MEM_DATA_W  : default data width
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_buf.sv
// Per-port result buffer: holds a done flag and the returned data until the
// pipeline advances.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   set_i        : transaction completed for this port (sets done)
//   load_i       : completed transaction returns data (0 = store, keep data)
//   set_data_i   : returned data, captured on set_i & load_i
//   clear_i      : pipeline advanced, drop done
//   flush_i      : port flushed, drop done
//   done_o       : result buffered
//   data_o       : buffered data
module mem_port_buf
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] set_data_i,
  input  logic              clear_i,
  input  logic              flush_i,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;

  // A completion on the same edge as an advance belongs to the new
  // instruction, so set wins over clear.
  always_comb begin
    done_d = done_q;
    data_d = data_q;
    if (clear_i || flush_i) begin
      done_d = 1'b0;
    end
    if (set_i) begin
      done_d = 1'b1;
      if (load_i) begin
        data_d = set_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= done_d;
      data_q <= data_d;
    end
  end

  assign done_o = done_q;
  assign data_o = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// the MEM-stage data port. Data wins over fetch, each port's result is
// buffered until the pipeline advances, and a combined stall is produced.
//   clk, rst_n                              : clock, async active-low reset
//   if_req/if_addr/if_flush                 : fetch request, PC, redirect pulse
//   if_rdata/if_done                        : buffered fetch result
//   dm_req/dm_we/dm_addr/dm_wdata           : load/store request
//   dm_rdata/dm_done                        : buffered data result
//   pipe_stall                              : pipeline-wide memory stall
//   mem_req/mem_we/mem_addr/mem_wdata       : memory command
//   mem_ack/mem_rdata                       : memory completion
//   mem_err                                 : sticky timeout flag
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = MEM_ADDR_W,
  parameter int unsigned DATA_W  = MEM_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              pipe_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_err
);

  // Counter only has to reach TIMEOUT-1 (the last waiting cycle).
  localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stale_q, stale_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              if_set, dm_set;
  logic              complete;
  logic              advance;
  logic [DATA_W-1:0] rsp_data;

  assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);
  assign advance    = ~pipe_stall;

  // Forced completion on the last allowed cycle returns zero data.
  assign complete = mem_ack | (cnt_q == CNT_LAST);
  assign rsp_data = mem_ack ? mem_rdata : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if_set  = 1'b0;
    dm_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req && !dm_done) begin
          state_d = DATA;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          cnt_d   = '0;
        end else if (if_req && !if_done && !if_flush) begin
          state_d = FETCH;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end

      FETCH: begin
        // Memory cannot abort: a redirect only marks the fetch stale and
        // its data is dropped at completion.
        if (if_flush) begin
          stale_d = 1'b1;
        end
        if (complete) begin
          state_d = IDLE;
          stale_d = 1'b0;
          cnt_d   = '0;
          if_set  = ~stale_q & ~if_flush;
          if (!mem_ack) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (complete) begin
          state_d = IDLE;
          cnt_d   = '0;
          dm_set  = 1'b1;
          if (!mem_ack) begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_err   = err_q;

  mem_port_buf #(
    .DATA_W(DATA_W)
  ) u_if_buf (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .set_i     (if_set),
    .load_i    (1'b1),
    .set_data_i(rsp_data),
    .clear_i   (advance),
    .flush_i   (if_flush),
    .done_o    (if_done),
    .data_o    (if_rdata)
  );

  mem_port_buf #(
    .DATA_W(DATA_W)
  ) u_dm_buf (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .set_i     (dm_set),
    .load_i    (~we_q),
    .set_data_i(rsp_data),
    .clear_i   (advance),
    .flush_i   (1'b0),
    .done_o    (dm_done),
    .data_o    (dm_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios from the
// timing rules plus a randomized pipeline/memory run against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_flush;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dm_done, pipe_stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_done   (dm_done),
    .pipe_stall(pipe_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // memory responder state
  int            lat_cfg = 0;   // <0: random 0..3
  int            rcnt = 0;
  int            lat  = 0;
  logic          new_grant = 1'b0;
  int            unstable = 0;
  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [DW-1:0] g_wdata;
  logic [DW-1:0] last_load = '0;

  // observation record of one run
  int            gcyc[8];
  logic [AW-1:0] gaddr[8];
  logic          gwe[8];
  logic [DW-1:0] gwd[8];
  int            ng, dm_first, if_first, free_cyc, req_cycles;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h0000_0040) return 32'h0050_0093;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock: advance past the edge, then act as the memory for this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    new_grant = 1'b0;
    if (!mem_req) begin
      rcnt      = 0;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end else begin
      if (rcnt == 0) begin
        lat       = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        g_addr    = mem_addr;
        g_we      = mem_we;
        g_wdata   = mem_wdata;
        new_grant = 1'b1;
      end else if (mem_addr !== g_addr || mem_we !== g_we || mem_wdata !== g_wdata) begin
        unstable++;
      end
      mem_ack   = (rcnt == lat);
      mem_rdata = mem_ack ? memf(mem_addr) : $urandom;
      rcnt++;
    end
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_flush = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
  endtask

  // Runs from cycle 0 (inputs already applied) until the stall drops,
  // optionally redirecting the PC at cycle flush_cyc.
  task automatic run_obs(input int flush_cyc, input logic [AW-1:0] new_pc, input int max_c);
    ng = 0; dm_first = -1; if_first = -1; free_cyc = -1; req_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      gcyc[i] = -1; gaddr[i] = 'x; gwe[i] = 1'bx; gwd[i] = 'x;
    end
    for (int c = 1; c <= max_c; c++) begin
      tick();
      if (c == flush_cyc) begin
        if_flush = 1'b1;
        if_addr  = new_pc;
      end else begin
        if_flush = 1'b0;
      end
      if (mem_req === 1'b1) req_cycles++;
      if (new_grant && ng < 8) begin
        gcyc[ng] = c; gaddr[ng] = mem_addr; gwe[ng] = mem_we; gwd[ng] = mem_wdata;
        ng++;
      end
      if (dm_done === 1'b1 && dm_first < 0) dm_first = c;
      if (if_done === 1'b1 && if_first < 0) if_first = c;
      if (pipe_stall === 1'b0) begin
        free_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_ack = 1'b0; mem_rdata = '0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    #1;
    n_checks++;
    if ({if_done, dm_done, mem_req, mem_we, mem_err, if_rdata, dm_rdata, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {if_done, dm_done, mem_req, mem_we, mem_err, if_rdata, dm_rdata, mem_addr, mem_wdata});
    else n_pass++;
    n_checks++;
    if (pipe_stall !== 1'b0) $display("FAIL reset_stall_idle: got %b required 0", pipe_stall);
    else n_pass++;
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    n_checks++;
    if (pipe_stall !== 1'b1) $display("FAIL reset_stall_follows: got %b required 1", pipe_stall);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (mem_req !== 1'b0) $display("FAIL reset_no_req: got %b required 0", mem_req);
    else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_zero();
    lat_cfg = 0;
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    run_obs(-1, '0, 20);
    n_checks++;
    if (gcyc[0] !== 1 || gaddr[0] !== 32'h40 || gwe[0] !== 1'b0)
      $display("FAIL fetch0_grant: got cyc %0d addr %h we %b required cyc 1 addr 40 we 0", gcyc[0], gaddr[0], gwe[0]);
    else n_pass++;
    n_checks++;
    if (if_first !== 2 || free_cyc !== 2)
      $display("FAIL fetch0_done_cycle: got done %0d free %0d required 2/2", if_first, free_cyc);
    else n_pass++;
    n_checks++;
    if (if_rdata !== 32'h0050_0093) $display("FAIL fetch0_data: got %h required 00500093", if_rdata);
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (if_done !== 1'b0) $display("FAIL fetch0_clear: got %b required 0", if_done);
    else n_pass++;
  endtask

  task automatic test_load_fetch();
    lat_cfg = 2;
    tick();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = 32'h1111_2222;
    if_req = 1'b1; if_addr = 32'h44;
    run_obs(-1, '0, 30);
    n_checks++;
    if (ng !== 2 || gcyc[0] !== 1 || gaddr[0] !== 32'h100 || gwe[0] !== 1'b0)
      $display("FAIL lf_data_first: got n %0d cyc %0d addr %h required n 2 cyc 1 addr 100", ng, gcyc[0], gaddr[0]);
    else n_pass++;
    n_checks++;
    if (dm_first !== 4 || gcyc[1] !== 5 || gaddr[1] !== 32'h44 || gwe[1] !== 1'b0)
      $display("FAIL lf_fetch_after: got dm_done %0d fetch cyc %0d addr %h required 4/5/44", dm_first, gcyc[1], gaddr[1]);
    else n_pass++;
    n_checks++;
    if (if_first !== 8 || free_cyc !== 8)
      $display("FAIL lf_release: got if_done %0d free %0d required 8/8", if_first, free_cyc);
    else n_pass++;
    n_checks++;
    if (dm_rdata !== memf(32'h100) || if_rdata !== memf(32'h44))
      $display("FAIL lf_data: got %h/%h required %h/%h", dm_rdata, if_rdata, memf(32'h100), memf(32'h44));
    else n_pass++;
    last_load = memf(32'h100);
    idle_inputs();
    tick();
    n_checks++;
    if (dm_done !== 1'b0 || if_done !== 1'b0)
      $display("FAIL lf_clear: got %b%b required 00", dm_done, if_done);
    else n_pass++;
  endtask

  task automatic test_store();
    int u0;
    lat_cfg = 3;
    u0 = unstable;
    tick();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    run_obs(-1, '0, 30);
    n_checks++;
    if (gcyc[0] !== 1 || gwe[0] !== 1'b1 || gaddr[0] !== 32'h200 || gwd[0] !== 32'hDEAD_BEEF)
      $display("FAIL st_cmd: got cyc %0d we %b addr %h wdata %h required 1/1/200/deadbeef", gcyc[0], gwe[0], gaddr[0], gwd[0]);
    else n_pass++;
    n_checks++;
    if (unstable !== u0 || req_cycles !== 4)
      $display("FAIL st_stable: got unstable %0d req cycles %0d required %0d/4", unstable, req_cycles, u0);
    else n_pass++;
    n_checks++;
    if (dm_first !== 5 || dm_rdata !== last_load)
      $display("FAIL st_done: got cyc %0d rdata %h required 5 %h", dm_first, dm_rdata, last_load);
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_flush(input int l, input int fc, input logic [AW-1:0] npc,
                            input int g2, input int done_c);
    lat_cfg = l;
    tick();
    if_req = 1'b1; if_addr = 32'h80;
    run_obs(fc, npc, 40);
    n_checks++;
    if (ng !== 2 || gaddr[0] !== 32'h80 || gcyc[1] !== g2 || gaddr[1] !== npc)
      $display("FAIL flush_refetch: got n %0d a0 %h c1 %0d a1 %h required 2 80 %0d %h", ng, gaddr[0], gcyc[1], gaddr[1], g2, npc);
    else n_pass++;
    n_checks++;
    if (if_first !== done_c || free_cyc !== done_c || if_rdata !== memf(npc))
      $display("FAIL flush_result: got done %0d free %0d data %h required %0d %h", if_first, free_cyc, if_rdata, done_c, memf(npc));
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    lat_cfg = 100;
    tick();
    if_req = 1'b1; if_addr = 32'h300;
    run_obs(-1, '0, 20);
    n_checks++;
    if (req_cycles !== TO || if_first !== TO + 1 || if_rdata !== '0)
      $display("FAIL to_forced: got req %0d done %0d data %h required %0d %0d 0", req_cycles, if_first, if_rdata, TO, TO + 1);
    else n_pass++;
    n_checks++;
    if (mem_err !== 1'b1) $display("FAIL to_err_set: got %b required 1", mem_err);
    else n_pass++;
    idle_inputs();
    tick();
    lat_cfg = 0;
    if_req = 1'b1; if_addr = 32'h304;
    run_obs(-1, '0, 20);
    n_checks++;
    if (mem_err !== 1'b1 || if_rdata !== memf(32'h304))
      $display("FAIL to_err_sticky: got err %b data %h required 1 %h", mem_err, if_rdata, memf(32'h304));
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    lat_cfg = 100;
    tick();
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    tick();
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL rm_inflight: got %b required 1", mem_req);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_err !== 1'b0 || if_done !== 1'b0 || if_rdata !== '0 || mem_addr !== '0)
      $display("FAIL rm_drop: got req %b err %b done %b data %h addr %h required all 0", mem_req, mem_err, if_done, if_rdata, mem_addr);
    else n_pass++;
    tick();
    idle_inputs();
    rst_n = 1'b1;
    last_load = '0;
    tick();
  endtask

  task automatic test_random(input int nslots);
    logic dm_ok, if_ok, stale, exp_stall, fin;
    int   busy, nflush, u0;
    lat_cfg = -1;
    u0 = unstable;
    for (int s = 0; s < nslots; s++) begin
      tick();
      if_flush = 1'b0;
      if_req   = ($urandom_range(0, 3) != 0);
      dm_req   = $urandom_range(0, 1) != 0;
      dm_we    = $urandom_range(0, 1) != 0;
      if_addr  = $urandom & 32'h0000_FFFC;
      dm_addr  = $urandom & 32'h0000_FFFC;
      dm_wdata = $urandom;
      dm_ok = 1'b0; if_ok = 1'b0; stale = 1'b0; busy = 0; nflush = 0; fin = 1'b0;
      for (int c = 0; c < 60 && !fin; c++) begin
        if (c > 0) begin
          tick();
          if_flush = 1'b0;
          if (new_grant) begin
            n_checks++;
            if (dm_req && !dm_ok) begin
              busy = 1;
              if (mem_we !== dm_we || mem_addr !== dm_addr || mem_wdata !== dm_wdata)
                $display("FAIL rnd_grant_data: got %b %h %h required %b %h %h", mem_we, mem_addr, mem_wdata, dm_we, dm_addr, dm_wdata);
              else n_pass++;
            end else if (if_req && !if_ok) begin
              busy = 2;
              if (mem_we !== 1'b0 || mem_addr !== if_addr)
                $display("FAIL rnd_grant_fetch: got %b %h required 0 %h", mem_we, mem_addr, if_addr);
              else n_pass++;
            end else begin
              $display("FAIL rnd_grant_spurious: got addr %h required no grant", mem_addr);
            end
          end
        end else begin
          #1;
        end
        exp_stall = (if_req & ~if_ok) | (dm_req & ~dm_ok);
        n_checks++;
        if (pipe_stall !== exp_stall)
          $display("FAIL rnd_stall: slot %0d cyc %0d got %b required %b", s, c, pipe_stall, exp_stall);
        else n_pass++;
        if (!exp_stall) begin
          fin = 1'b1;
          n_checks++;
          if (if_done !== if_req || dm_done !== dm_req)
            $display("FAIL rnd_done: got %b%b required %b%b", if_done, dm_done, if_req, dm_req);
          else n_pass++;
          if (if_req) begin
            n_checks++;
            if (if_rdata !== memf(if_addr)) $display("FAIL rnd_if_data: got %h required %h", if_rdata, memf(if_addr));
            else n_pass++;
          end
          if (dm_req) begin
            if (!dm_we) last_load = memf(dm_addr);
            n_checks++;
            if (dm_rdata !== last_load) $display("FAIL rnd_dm_data: got %h required %h", dm_rdata, last_load);
            else n_pass++;
          end
        end else if (c > 0) begin
          if (if_req && !if_ok && nflush < 2 && $urandom_range(0, 7) == 0) begin
            if_flush = 1'b1;
            if_addr  = $urandom & 32'h0000_FFFC;
            nflush++;
            if (busy == 2) stale = 1'b1;
          end
          if (mem_ack && busy == 1) begin
            dm_ok = 1'b1; busy = 0;
          end else if (mem_ack && busy == 2) begin
            if_ok = ~stale; stale = 1'b0; busy = 0;
          end
        end
      end
      if (!fin) begin
        n_checks++;
        $display("FAIL rnd_slot_timeout: slot %0d got stall after 60 cycles required release", s);
      end
    end
    if_flush = 1'b0;
    idle_inputs();
    tick();
    n_checks++;
    if (unstable !== u0 || mem_err !== 1'b0)
      $display("FAIL rnd_stable_noerr: got unstable %0d err %b required %0d 0", unstable, mem_err, u0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_zero();
    test_load_fetch();
    test_store();
    test_flush(3, 2, 32'hC0, 6, 10);
    test_flush(2, 3, 32'hC4, 5, 8);
    test_timeout();
    test_reset_mid();
    test_random(150);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog");
  end

endmodule
